gpio_input_filter: RTL and testbench

Input conditioning stage that sits directly upstream of the GPIO peripheral's `input_i` port. It synchronises 16 asynchronous pad inputs, debounces each channel with a per-channel counter, and drives the filtered levels to the GPIO block. It also detects rising and falling edges on the filtered levels, latches them in a write-1-to-clear pending register, and raises a level interrupt. Software reaches it through the same small register bus used by the GPIO block.

---
 rtl/gpio_input_filter.sv | 139 +++++++++++++
 tb/tb_gpio_input_filter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_input_filter.sv
// Purpose     : pad input conditioning for GPIO: 2-flop sync, per-channel debounce,
//               edge detect into a W1C pending register with a level interrupt.
// Latency     : pad to input_o is 2 sync flops plus DEBOUNCE_CYCLES qualify cycles
//               (macro defined) or one further flop (macro undefined).
// Backpressure: none; pads are sampled every cycle and the register bus never stalls.
//
// Ports: clk_i/rst_ni (sync active-low); write_i, addr_i, wdata_i, rdata_o form the
//        register bus (0:PEND W1C, 2:RISE_EN, 4:FALL_EN, 6:RAW read-only);
//        pad_i raw pads, input_o filtered levels, irq_o = |PEND.
// Build option: define GPIO_INPUT_FILTER_DEBOUNCE_EN to include the per-channel
//        debounce counters; without it the filtered level follows s2 one cycle later.
module gpio_input_filter #(
   parameter int WIDTH           = 16,
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              write_i,
   input  logic [2:0]        addr_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o,
   input  logic [WIDTH-1:0]  pad_i,
   output logic [WIDTH-1:0]  input_o,
   output logic              irq_o
);

   // Registers are halfwords, so the channel count is pinned to 16.
   if (WIDTH != 16) begin : g_width_chk
      $error("gpio_input_filter: WIDTH must be 16");
   end
   if (DEBOUNCE_CYCLES < 1) begin : g_db_chk
      $error("gpio_input_filter: DEBOUNCE_CYCLES must be at least 1");
   end

   logic [WIDTH-1:0] s1, s2, stable;
   logic [WIDTH-1:0] upd;          // channels whose stable level flips this edge
   logic [WIDTH-1:0] evt;
   logic [WIDTH-1:0] pend, rise_en, fall_en;
   logic             wr_pend, wr_rise, wr_fall;
   logic             unused_wdata;

   assign unused_wdata = ^wdata_i[31:WIDTH];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= pad_i;
         s2 <= s1;
      end
   end

`ifdef GPIO_INPUT_FILTER_DEBOUNCE_EN
   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] cnt [WIDTH];

   // A level is accepted only once s2 has differed from stable for
   // DEBOUNCE_CYCLES consecutive edges; any return to stable restarts the count.
   always_comb begin
      upd = '0;
      for (int i = 0; i < WIDTH; i++) begin
         upd[i] = (s2[i] != stable[i]) && (cnt[i] == CNT_MAX);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if ((s2[i] == stable[i]) || upd[i]) begin
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end
`else
   always_comb begin
      upd = s2 ^ stable;
   end
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         stable <= '0;
      end else begin
         stable <= stable ^ upd;
      end
   end

   assign input_o = stable;

   // After a flip, s2 holds the new level: 1 means a rising edge, 0 falling.
   assign evt = (upd & s2 & rise_en) | (upd & ~s2 & fall_en);

   assign wr_pend = write_i && (addr_i == 3'h0);
   assign wr_rise = write_i && (addr_i == 3'h2);
   assign wr_fall = write_i && (addr_i == 3'h4);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pend    <= '0;
         rise_en <= '0;
         fall_en <= '0;
      end else begin
         // OR-ing evt after the clear lets a same-edge event win over W1C.
         pend <= (pend & ~(wr_pend ? wdata_i[WIDTH-1:0] : '0)) | evt;
         if (wr_rise) begin
            rise_en <= wdata_i[WIDTH-1:0];
         end
         if (wr_fall) begin
            fall_en <= wdata_i[WIDTH-1:0];
         end
      end
   end

   assign irq_o = |pend;

   always_comb begin
      rdata_o = '0;
      if (!addr_i[0]) begin
         case (addr_i[2:1])
            2'd0:    rdata_o[WIDTH-1:0] = pend;
            2'd1:    rdata_o[WIDTH-1:0] = rise_en;
            2'd2:    rdata_o[WIDTH-1:0] = fall_en;
            2'd3:    rdata_o[WIDTH-1:0] = s2;
            default: rdata_o = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_gpio_input_filter.sv
// Purpose     : directed scoreboard bench for gpio_input_filter.
// Latency     : expected input_o changes carry the exact edge they must land on.
// Backpressure: n/a; a negedge monitor pops expectations as the DUT presents them.
module tb_gpio_input_filter;

   localparam int DB = 4;
`ifdef GPIO_INPUT_FILTER_DEBOUNCE_EN
   localparam int LAT = 2 + DB;   // pad driven after edge N: s1@N+1, s2@N+2, accept @N+2+DB
`else
   localparam int LAT = 3;        // s1@N+1, s2@N+2, stable@N+3
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        write;
   logic [2:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [15:0] pad;
   logic [15:0] inp;
   logic        irq;

   gpio_input_filter #(.WIDTH(16), .DEBOUNCE_CYCLES(DB)) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .write_i (write),
      .addr_i  (addr),
      .wdata_i (wdata),
      .rdata_o (rdata),
      .pad_i   (pad),
      .input_o (inp),
      .irq_o   (irq)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          at;
      logic [15:0] val;
   } in_exp_t;

   typedef struct {
      string       name;
      logic [31:0] rd;
      logic        irq;
      logic [15:0] inp;
   } rd_exp_t;

   in_exp_t in_q[$];
   rd_exp_t rd_q[$];
   logic    rd_stb = 1'b0;
   int      checks = 0;
   int      passes = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: every input_o change and every strobed read is checked against the queues.
   logic [15:0] prev_in = '0;
   always @(negedge clk) begin
      in_exp_t ie;
      rd_exp_t re;
      if (inp !== prev_in) begin
         if (in_q.size() == 0) begin
            chk("unexpected_input_change", {16'h0, inp}, {16'h0, prev_in});
         end else begin
            ie = in_q.pop_front();
            chk("input_o", {16'h0, inp}, {16'h0, ie.val});
            chk("input_o_edge", cyc, ie.at);
         end
         prev_in = inp;
      end
      if (rd_stb) begin
         if (rd_q.size() == 0) begin
            chk("read_without_expectation", 32'd1, 32'd0);
         end else begin
            re = rd_q.pop_front();
            chk({re.name, "_rdata"}, rdata, re.rd);
            chk({re.name, "_irq"}, {31'h0, irq}, {31'h0, re.irq});
            chk({re.name, "_input"}, {16'h0, inp}, {16'h0, re.inp});
         end
      end
   end

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_in(int at, logic [15:0] v);
      in_exp_t e;
      e.at  = at;
      e.val = v;
      in_q.push_back(e);
   endtask

   // Read checked at the negedge of the current cycle; consumes one edge.
   task automatic rd(string name, logic [2:0] a, logic [31:0] exp_rd, logic exp_irq,
                     logic [15:0] exp_in);
      rd_exp_t e;
      e.name = name;
      e.rd   = exp_rd;
      e.irq  = exp_irq;
      e.inp  = exp_in;
      rd_q.push_back(e);
      addr   = a;
      rd_stb = 1'b1;
      tick(1);
      rd_stb = 1'b0;
   endtask

   // Write sampled on the next edge.
   task automatic wr(logic [2:0] a, logic [31:0] d);
      addr  = a;
      wdata = d;
      write = 1'b1;
      tick(1);
      write = 1'b0;
   endtask

   initial begin
      int n;
      int r;
      rst_n = 1'b0;
      pad   = 16'hFFFF;
      write = 1'b0;
      addr  = 3'h0;
      wdata = '0;

      // Reset with all pads high, enables left at 0.
      tick(3);
      rd("rst_pend", 3'h0, 32'h0, 1'b0, 16'h0);
      rd("rst_rise_en", 3'h2, 32'h0, 1'b0, 16'h0);
      rst_n = 1'b1;
      r = cyc;
      expect_in(r + LAT, 16'hFFFF);
      tick(LAT - 1);
      rd("pre_accept_raw", 3'h6, 32'h0000FFFF, 1'b0, 16'h0);
      rd("hold_high_pend", 3'h0, 32'h0, 1'b0, 16'hFFFF);

      pad = 16'h0000;
      n = cyc;
      expect_in(n + LAT, 16'h0000);
      tick(LAT + 1);

      // Rising edge on channel 0.
      wr(3'h2, 32'h1);
      rd("rise_en_rb", 3'h2, 32'h1, 1'b0, 16'h0);
      pad = 16'h0001;
      n = cyc;
      expect_in(n + LAT, 16'h0001);
      tick(LAT - 1);
      rd("rise_before", 3'h0, 32'h0, 1'b0, 16'h0);
      rd("rise_pend", 3'h0, 32'h1, 1'b1, 16'h0001);
      wr(3'h0, 32'h1);
      rd("rise_w1c", 3'h0, 32'h0, 1'b0, 16'h0001);

      // Three-cycle glitch on channel 3.
      pad = 16'h0009;
      n = cyc;
`ifndef GPIO_INPUT_FILTER_DEBOUNCE_EN
      expect_in(n + 3, 16'h0009);
      expect_in(n + 6, 16'h0001);
`endif
      tick(3);
      pad = 16'h0001;
      tick(8);
      rd("glitch_pend", 3'h0, 32'h0, 1'b0, 16'h0001);

      // Falling edge on channel 15 racing a W1C on the same edge.
      wr(3'h4, 32'h8000);
      pad = 16'h8001;
      n = cyc;
      expect_in(n + LAT, 16'h8001);
      tick(LAT + 1);
      rd("fall_en_rb", 3'h4, 32'h8000, 1'b0, 16'h8001);
      pad = 16'h0001;
      n = cyc;
      expect_in(n + LAT, 16'h0001);
      tick(LAT - 1);
      wr(3'h0, 32'h8000);
      rd("w1c_vs_event", 3'h0, 32'h8000, 1'b1, 16'h0001);
      wr(3'h0, 32'h8000);
      rd("w1c_clear", 3'h0, 32'h0, 1'b0, 16'h0001);

      // Bus rules.
      rd("odd_addr1", 3'h1, 32'h0, 1'b0, 16'h0001);
      rd("odd_addr3", 3'h3, 32'h0, 1'b0, 16'h0001);
      wr(3'h6, 32'hFFFF);
      rd("raw_readonly", 3'h6, 32'h1, 1'b0, 16'h0001);
      wr(3'h2, 32'hFFFF_00FF);
      rd("rise_en_wr", 3'h2, 32'h000000FF, 1'b0, 16'h0001);
      wr(3'h3, 32'h0);
      rd("odd_write_ignored", 3'h2, 32'h000000FF, 1'b0, 16'h0001);

      // Reset while channel 1 is part-way through qualifying.
      pad = 16'h0003;
      n = cyc;
`ifndef GPIO_INPUT_FILTER_DEBOUNCE_EN
      expect_in(n + 3, 16'h0003);
`endif
      tick(4);
      rst_n = 1'b0;
      expect_in(n + 5, 16'h0000);
      tick(1);
      rst_n = 1'b1;
      r = cyc;
      expect_in(r + LAT, 16'h0003);
      rd("post_rst_pend", 3'h0, 32'h0, 1'b0, 16'h0);
      rd("post_rst_rise_en", 3'h2, 32'h0, 1'b0, 16'h0);
      tick(LAT - 3);
      rd("requal_before", 3'h6, 32'h3, 1'b0, 16'h0);
      rd("requal_after", 3'h0, 32'h0, 1'b0, 16'h0003);

      tick(5);
      while (in_q.size() != 0) begin
         in_exp_t e;
         e = in_q.pop_front();
         chk("missing_input_change", {16'h0, prev_in}, {16'h0, e.val});
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #100000;
      checks++;
      $display("FAIL watchdog: stimulus still running at cycle %0d, required done", cyc);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
